feature_map_assembler: RTL
==========================

# feature_map_assembler

Streaming inverse of the flatten stage. Accepts a flattened feature vector one element per beat over a valid/ready handshake and writes each element into a 3D buffer of 8 channels x 6 rows x 6 cols. When the buffer is full, it presents the complete map to a downstream consumer. It sits between a serial element source (DMA/UART unpacker or FC-side stream) and any layer that takes a packed 3D feature map. Its packing is bit-identical to the flatten layer's input layout, so flatten followed by this block is the identity.

## Interface
- INPUT_CHANNELS, 8, number of channels
- FEATURE_BITWIDTH, 8, bits per element
- MAP_WIDTH, 6, columns per channel
- MAP_HEIGHT, 6, rows per channel
- TOTAL (derived), INPUT_CHANNELS*MAP_HEIGHT*MAP_WIDTH = 288, elements per frame
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- soft_rst  in  1  synchronous clear, same effect as reset
- in_valid  in  1  element beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  FEATURE_BITWIDTH  element value
- in_last  in  1  marks final element of a frame
- map_valid  out  1  complete map is presented
- map_ready  in  1  consumer takes the map
- feature_map_out  out  TOTAL*FEATURE_BITWIDTH  packed map; element (k,i,j) at index (k*MAP_HEIGHT+i)*MAP_WIDTH+j, slice [idx*FEATURE_BITWIDTH +: FEATURE_BITWIDTH]
- fill_count  out  clog2(TOTAL+1)  elements accepted in the current frame
- frame_error  out  1  one-cycle pulse on in_last mismatch

## Operation
- Reset (rst_n low, or soft_rst high at a clk edge): state FILL; in_ready=1; map_valid=0; frame_error=0; fill_count=0; col/row/ch counters=0; buffer all zero. Priority: rst_n > soft_rst > normal operation.
- FILL: in_ready=1, map_valid=0. A beat is accepted when in_valid&&in_ready. It writes in_data to the element at the current (ch,row,col).
- Counter advance order: col fastest, then row, then ch. Each counter wraps to 0 at its maximum, and the wrap carries into the next counter. fill_count increments by 1 per accepted beat.
- Final beat (fill_count==TOTAL-1 when accepted): write the element, go to FULL, clear the counters, and set fill_count=TOTAL.
- FULL: in_ready=0, map_valid=1. feature_map_out holds stable. On map_ready: go to FILL, set fill_count=0, and drop map_valid next cycle.
- The buffer is not cleared between frames. Every element is overwritten before the next map_valid, so no stale data is ever presented.
- in_last rules:
  - Early last (in_last on an accepted non-final beat): write the element, pulse frame_error, abort the frame (counters and fill_count back to 0), stay in FILL.
  - Missing last (final beat without in_last): the frame still completes to FULL, and frame_error pulses.
- in_valid while in FULL is ignored. The source must hold the beat per the handshake rules.

## Timing
- Beat acceptance: 1 per cycle in FILL. Minimum frame period is TOTAL+1 cycles (288 fill + 1 handoff).
- map_valid rises the cycle after the final beat is accepted. feature_map_out is already complete in that same cycle.
- Handshake: map_valid, once high, stays high with the data stable until the map_ready cycle. in_ready may drop only at the FILL->FULL transition.
- No overlap: in the map_ready cycle in_ready is still 0. The first beat of the next frame is accepted no earlier than the following cycle.
- frame_error is registered, high exactly one cycle after the offending beat.
- soft_rst mid-frame or in FULL discards the frame. Outputs reach their reset values on the next cycle.

## Structure
- Shared package cnn_pkg: default dimension constants (8/8/6/6), TOTAL, count width, and the FILL/FULL state enum. The flatten layer uses the same constants.
- Sub-module map_index_counter: nested col/row/ch counter with enable, clear, linear-index output and terminal flag. The top level holds the FSM, the in_last check and the buffer.

## Test plan
- Reset then stream 288 beats back-to-back, in_data=idx[7:0], in_last on beat 287 -> map_valid high at cycle 289; slice 287 reads 0x1F, slice 36 (ch1,row0,col0) reads 0x24; frame_error stays 0.
- Hold map_ready=0 for 20 cycles after a full frame -> map_valid and data stable, in_ready=0, in_valid ignored; after map_ready, the next frame is accepted starting the following cycle.
- Early in_last on beat 10 -> frame_error pulse, fill_count returns to 0; a following clean 288-beat frame completes correctly.
- Final beat without in_last -> map_valid asserts and frame_error pulses once.
- soft_rst at beat 100, then a full frame of 0xA5 -> all 288 slices read 0xA5; random in_valid gaps give identical results.
- Round trip: flatten layer output serialized into this block -> feature_map_out equals the original 2304-bit input.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN geometry: default feature-map dimensions, derived sizes and the
// fill/full state type used by the flatten / assembler pair.
package cnn_pkg;

  localparam int CNN_CHANNELS  = 8;
  localparam int CNN_FEAT_BITS = 8;
  localparam int CNN_MAP_W     = 6;
  localparam int CNN_MAP_H     = 6;
  localparam int CNN_TOTAL     = CNN_CHANNELS * CNN_MAP_H * CNN_MAP_W;
  localparam int CNN_CNT_W     = $clog2(CNN_TOTAL + 1);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } map_state_e;

  // Linear element index of (ch,row,col) in the packed map layout.
  function automatic int map_index(input int ch, input int row, input int col);
    return (ch * CNN_MAP_H + row) * CNN_MAP_W + col;
  endfunction

endpackage

// File: rtl/map_index_counter.sv
// Nested col/row/ch position counter. col advances fastest; each wrap carries
// into the next level. Exposes the linear element index and a terminal flag
// that is high when the counter sits on the last element of the map.
module map_index_counter #(
  parameter int CHANNELS = 8,
  parameter int ROWS     = 6,
  parameter int COLS     = 6,
  parameter int IDX_W    = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             term
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [CH_W-1:0]  ch_q;
  logic             col_wrap, row_wrap, ch_wrap;

  assign col_wrap = (col_q == COL_W'(COLS - 1));
  assign row_wrap = (row_q == ROW_W'(ROWS - 1));
  assign ch_wrap  = (ch_q  == CH_W'(CHANNELS - 1));
  assign term     = col_wrap && row_wrap && ch_wrap;
  assign idx      = IDX_W'((int'(ch_q) * ROWS + int'(row_q)) * COLS + int'(col_q));

  // Ripple-carry style nested advance; clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      ch_q  <= '0;
    end else if (clr) begin
      col_q <= '0;
      row_q <= '0;
      ch_q  <= '0;
    end else if (en) begin
      if (col_wrap) begin
        col_q <= '0;
        if (row_wrap) begin
          row_q <= '0;
          ch_q  <= ch_wrap ? '0 : ch_q + 1'b1;
        end else begin
          row_q <= row_q + 1'b1;
        end
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/feature_map_assembler.sv
// Streaming un-flatten: collects one element per beat into a CxHxW buffer and
// presents the whole packed map once the last element lands. Checks in_last
// against the element position and pulses frame_error on a mismatch.
module feature_map_assembler
  import cnn_pkg::*;
#(
  parameter int INPUT_CHANNELS   = CNN_CHANNELS,
  parameter int FEATURE_BITWIDTH = CNN_FEAT_BITS,
  parameter int MAP_WIDTH        = CNN_MAP_W,
  parameter int MAP_HEIGHT       = CNN_MAP_H,
  parameter int TOTAL            = INPUT_CHANNELS * MAP_HEIGHT * MAP_WIDTH,
  parameter int CNT_W            = $clog2(TOTAL + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              soft_rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [FEATURE_BITWIDTH-1:0]       in_data,
  input  logic                              in_last,
  output logic                              map_valid,
  input  logic                              map_ready,
  output logic [TOTAL*FEATURE_BITWIDTH-1:0] feature_map_out,
  output logic [CNT_W-1:0]                  fill_count,
  output logic                              frame_error
);

  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  map_state_e state_q, state_d;

  logic [TOTAL-1:0][FEATURE_BITWIDTH-1:0] fmap_q;
  logic [IDX_W-1:0]                       wr_idx;
  logic                                   at_term;
  logic                                   accept, final_beat, early_last;
  logic [CNT_W-1:0]                       fill_q;
  logic                                   err_q;

  assign in_ready        = (state_q == ST_FILL);
  assign map_valid       = (state_q == ST_FULL);
  assign accept          = in_valid && (state_q == ST_FILL);
  // The counter's terminal position coincides with fill_count == TOTAL-1.
  assign final_beat      = accept && at_term;
  assign early_last      = accept && in_last && !at_term;
  assign feature_map_out = fmap_q;
  assign fill_count      = fill_q;
  assign frame_error     = err_q;

  map_index_counter #(
    .CHANNELS (INPUT_CHANNELS),
    .ROWS     (MAP_HEIGHT),
    .COLS     (MAP_WIDTH),
    .IDX_W    (IDX_W)
  ) u_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (soft_rst || final_beat || early_last),
    .en    (accept),
    .idx   (wr_idx),
    .term  (at_term)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        state_q <= ST_FILL;
    else if (soft_rst) state_q <= ST_FILL;
    else               state_q <= state_d;
  end

  // Next state: fill until the terminal element, hold until the consumer takes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: if (final_beat) state_d = ST_FULL;
      ST_FULL: if (map_ready)  state_d = ST_FILL;
      default: state_d = ST_FILL;
    endcase
  end

  // Element buffer; never cleared between frames since every slot is rewritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        fmap_q <= '0;
    else if (soft_rst) fmap_q <= '0;
    else if (accept)   fmap_q[wr_idx] <= in_data;
  end

  // Accepted-element count for the current frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                fill_q <= '0;
    else if (soft_rst)                         fill_q <= '0;
    else if (final_beat)                       fill_q <= CNT_W'(TOTAL);
    else if (early_last)                       fill_q <= '0;
    else if (accept)                           fill_q <= fill_q + 1'b1;
    else if (state_q == ST_FULL && map_ready)  fill_q <= '0;
  end

  // One-cycle pulse when in_last disagrees with the element position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        err_q <= 1'b0;
    else if (soft_rst) err_q <= 1'b0;
    else               err_q <= accept && (in_last != at_term);
  end

endmodule
